// File: rtl/game_pkg.sv
// game_pkg: shared types for the match controller and the per-player movement/attack FSMs.
package game_pkg;
  typedef enum logic [2:0] {ATTRACT, COUNTDOWN, FIGHT, KO_FREEZE, GAME_OVER, PAUSED} match_state_t;
  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1 = 2'd1;
  localparam logic [1:0] WIN_P2 = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;
  typedef enum logic [1:0] {MV_IDLE, MV_WALK, MV_JUMP, MV_FALL} movement_state;
  typedef enum logic [1:0] {ATK_IDLE, ATK_STARTUP, ATK_ACTIVE, ATK_RECOVERY} attack_state;
  function automatic int cnt_width(int a, int b, int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/match_controller_frame_timer.sv
// frame_timer: frame_tick-qualified counter; done fires on the tick where the count equals limit (terminal count).
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick,
  input  logic         en,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         done
);
  logic [W-1:0] cnt;
  assign done = en & tick & (cnt == limit);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clear || done) cnt <= '0;
    else if (en && tick) cnt <= cnt + 1'b1;
endmodule

// File: rtl/match_controller.sv
// match_controller: attract/countdown/fight/KO/game-over sequencer with round reset and HUD outputs.
// Optional PAUSED state when PAUSE_EN is defined.
module match_controller
  import game_pkg::*;
#(
  parameter int FRAMES_PER_COUNT = 60,
  parameter int COUNT_START = 3,
  parameter int KO_FREEZE_FRAMES = 90,
  parameter int GAMEOVER_FRAMES = 300
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start1,
  input  logic       start2,
  input  logic       respawn1,
  input  logic       respawn2,
  input  logic [1:0] stocks1,
  input  logic [1:0] stocks2,
  output logic       round_reset,
  output logic       input_en,
  output logic       freeze,
  output logic [1:0] countdown,
  output logic [2:0] match_state,
  output logic [1:0] winner
);
  localparam int W = cnt_width(FRAMES_PER_COUNT, KO_FREEZE_FRAMES, GAMEOVER_FRAMES);
  match_state_t state, state_d;
  logic start_q, start_edge, timed, done;
  logic [W-1:0] limit;
  logic [1:0] countdown_d, winner_d;
  assign start_edge = (start1 | start2) & ~start_q;
  assign timed = state inside {COUNTDOWN, KO_FREEZE, GAME_OVER};
  assign limit = state == COUNTDOWN ? W'(FRAMES_PER_COUNT - 1) :
                 state == KO_FREEZE ? W'(KO_FREEZE_FRAMES - 1) : W'(GAMEOVER_FRAMES - 1);
  assign match_state = state;
  frame_timer #(.W(W)) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .tick(frame_tick),
    .en(timed),
    .clear(state_d != state),
    .limit(limit),
    .done(done)
  );
  always_comb begin
    state_d = state;
    countdown_d = countdown;
    winner_d = winner;
    case (state)
      ATTRACT: if (start_edge) begin
        state_d = COUNTDOWN;
        countdown_d = 2'(COUNT_START);
        winner_d = WIN_NONE;
      end
      COUNTDOWN: if (done) begin
        countdown_d = countdown - 2'd1;
        if (countdown == 2'd1) state_d = FIGHT;
      end
      FIGHT: if (respawn1 || respawn2) state_d = KO_FREEZE;
`ifdef PAUSE_EN
      else if (start_edge) state_d = PAUSED;
`endif
      // stocks are sampled at exit so late decrements from the hit FSM are absorbed
      KO_FREEZE: if (done) begin
        winner_d = stocks1 == 2'd0 && stocks2 == 2'd0 ? WIN_DRAW :
                   stocks1 == 2'd0 ? WIN_P2 : stocks2 == 2'd0 ? WIN_P1 : WIN_NONE;
        state_d = winner_d == WIN_NONE ? FIGHT : GAME_OVER;
      end
      GAME_OVER: if (done) state_d = ATTRACT;
`ifdef PAUSE_EN
      PAUSED: if (start_edge) state_d = FIGHT;
`endif
      default: state_d = ATTRACT;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= ATTRACT;
      start_q <= 1'b0;
      countdown <= 2'd0;
      winner <= WIN_NONE;
      round_reset <= 1'b0;
      input_en <= 1'b0;
      freeze <= 1'b0;
    end else begin
      state <= state_d;
      start_q <= start1 | start2;
      countdown <= countdown_d;
      winner <= winner_d;
      round_reset <= state == ATTRACT && state_d == COUNTDOWN;
      input_en <= state_d == FIGHT;
      freeze <= state_d != FIGHT;
    end
endmodule
